// File: rtl/lfsr_seq_gen.sv
// ---------------------------------------------------------------------------
// lfsr_seq_gen
//
// Purpose:
//   Runtime-configurable maximal-length-sequence generator for the DAC
//   excitation path. A Fibonacci LFSR, shifting left with feedback into the
//   LSB, is stepped once per chip. A chip lasts sel_div_i+1 clock cycles.
//   Each period is 2^width_p-1 chips and starts again from the latched seed.
//   The generator runs either for rep_i periods (a burst) or, when rep_i is
//   0, until stop_i is asserted.
//
// Ports:
//   clk          system clock
//   arst         asynchronous active-high reset
//   start_i      single-cycle start request, only honoured while idle
//   stop_i       abort request; while idle it also masks a simultaneous start
//   mask_i       feedback tap mask, latched at start
//   seed_i       initial LFSR state (0 is replaced by all-ones), latched at start
//   sel_div_i    chip length minus one, in clk cycles, latched at start
//   rep_i        periods per burst, 0 = continuous, latched at start
//   sig_o        current chip value (LFSR MSB, 0 when idle)
//   chip_stb_o   pulse on the first clk of every chip
//   period_end_o pulse on the last clk of every complete period
//   busy_o       generator running
//   done_o       pulse on the cycle after the final period of a burst
//   state_o      current LFSR state (debug, 0 when idle)
// ---------------------------------------------------------------------------
module lfsr_seq_gen #(
    parameter int width_p     = 8,
    parameter int div_width_p = 8,
    parameter int rep_width_p = 8
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [width_p-1:0]     mask_i,
    input  logic [width_p-1:0]     seed_i,
    input  logic [div_width_p-1:0] sel_div_i,
    input  logic [rep_width_p-1:0] rep_i,
    output logic                   sig_o,
    output logic                   chip_stb_o,
    output logic                   period_end_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [width_p-1:0]     state_o
);

    localparam logic [0:0] st_idle = 1'b0;
    localparam logic [0:0] st_run  = 1'b1;

    // Index of the last chip in a period: 2^width_p-2.
    localparam logic [width_p-1:0] last_chip = {{(width_p-1){1'b1}}, 1'b0};

    logic [0:0]             fsm_q;
    logic [width_p-1:0]     lfsr_q;
    logic [width_p-1:0]     mask_q;
    logic [width_p-1:0]     seed_q;
    logic [div_width_p-1:0] div_q;
    logic [rep_width_p-1:0] rep_q;
    logic [div_width_p-1:0] div_cnt_q;
    logic [width_p-1:0]     chip_cnt_q;
    logic [rep_width_p-1:0] rep_cnt_q;
    logic                   done_q;

    logic                   running;
    logic                   div_wrap;
    logic                   chip_last;
    logic                   feedback;
    logic [rep_width_p-1:0] rep_next;
    logic                   burst_over;
    logic [width_p-1:0]     seed_eff;

    // Decode of the counters and the next-state helpers.
    always_comb begin
        running    = (fsm_q == st_run);
        div_wrap   = (div_cnt_q == div_q);
        chip_last  = (chip_cnt_q == last_chip);
        feedback   = ^(lfsr_q & mask_q);
        rep_next   = rep_cnt_q + 1'b1;
        burst_over = (rep_q != '0) && (rep_next == rep_q);
        // An all-zero seed would lock the register up, so substitute all-ones.
        seed_eff   = (seed_i == '0) ? '1 : seed_i;
    end

    // The LFSR register is cleared whenever the generator is idle, so the
    // chip value and the debug state read 0 outside a run without extra muxing.
    always_comb begin
        busy_o       = running;
        sig_o        = lfsr_q[width_p-1];
        state_o      = lfsr_q;
        chip_stb_o   = running && (div_cnt_q == '0);
        period_end_o = running && div_wrap && chip_last;
        done_o       = done_q;
    end

    // Main sequencer. In IDLE it latches the configuration on start. In RUN
    // the divider is stepped every clk, the LFSR every chip, and at each
    // period boundary the state is reloaded from the seed rather than shifted,
    // so that non-maximal masks still give identical periods.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fsm_q      <= st_idle;
            lfsr_q     <= '0;
            mask_q     <= '0;
            seed_q     <= '0;
            div_q      <= '0;
            rep_q      <= '0;
            div_cnt_q  <= '0;
            chip_cnt_q <= '0;
            rep_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                st_idle: begin
                    if (start_i && !stop_i) begin
                        fsm_q      <= st_run;
                        mask_q     <= mask_i;
                        seed_q     <= seed_eff;
                        div_q      <= sel_div_i;
                        rep_q      <= rep_i;
                        lfsr_q     <= seed_eff;
                        div_cnt_q  <= '0;
                        chip_cnt_q <= '0;
                        rep_cnt_q  <= '0;
                    end
                end
                st_run: begin
                    if (stop_i) begin
                        fsm_q      <= st_idle;
                        lfsr_q     <= '0;
                        div_cnt_q  <= '0;
                        chip_cnt_q <= '0;
                        rep_cnt_q  <= '0;
                    end else if (!div_wrap) begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end else begin
                        div_cnt_q <= '0;
                        if (!chip_last) begin
                            chip_cnt_q <= chip_cnt_q + 1'b1;
                            lfsr_q     <= {lfsr_q[width_p-2:0], feedback};
                        end else begin
                            chip_cnt_q <= '0;
                            if (burst_over) begin
                                fsm_q     <= st_idle;
                                lfsr_q    <= '0;
                                rep_cnt_q <= '0;
                                done_q    <= 1'b1;
                            end else begin
                                lfsr_q    <= seed_q;
                                rep_cnt_q <= rep_next;
                            end
                        end
                    end
                end
                default: begin
                    fsm_q <= st_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_lfsr_seq_gen
//
// Purpose:
//   Self-checking bench for lfsr_seq_gen with width_p=3. A table of burst
//   configurations is checked against hand-derived constants, random bursts
//   are checked clock by clock against a reference model, and hand-written
//   sequences cover continuous mode, stop, start/stop collisions, start while
//   busy, back-to-back bursts and asynchronous reset.
//
//   The reference model works from the cycle index since start: the chip
//   index is t/(sel_div+1), the position inside the period is that modulo 7,
//   and the expected state is read from a precomputed list of seven states.
// ---------------------------------------------------------------------------
module tb_lfsr_seq_gen;

    logic       clk;
    logic       arst;
    logic       start_i;
    logic       stop_i;
    logic [2:0] mask_i;
    logic [2:0] seed_i;
    logic [7:0] sel_div_i;
    logic [7:0] rep_i;
    logic       sig_o;
    logic       chip_stb_o;
    logic       period_end_o;
    logic       busy_o;
    logic       done_o;
    logic [2:0] state_o;

    int checks;
    int errors;

    logic [2:0] ref_seq [7];

    typedef struct {
        logic [2:0]  mask;
        logic [2:0]  seed;
        logic [7:0]  div;
        logic [7:0]  rep;
        int          exp_busy;
        int          exp_pe;
        logic [20:0] exp_seq;
    } vec_t;

    vec_t vecs [5];

    lfsr_seq_gen #(
        .width_p     (3),
        .div_width_p (8),
        .rep_width_p (8)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mask_i       (mask_i),
        .seed_i       (seed_i),
        .sel_div_i    (sel_div_i),
        .rep_i        (rep_i),
        .sig_o        (sig_o),
        .chip_stb_o   (chip_stb_o),
        .period_end_o (period_end_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .state_o      (state_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check passes through here.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Builds the seven states of one period from the spec rules: a zero seed
    // becomes all-ones, each step shifts left and appends the parity of the
    // tapped bits.
    task automatic build_ref(input logic [2:0] m, input logic [2:0] s);
        logic [2:0] cur;
        cur = (s == 3'd0) ? 3'd7 : s;
        for (int i = 0; i < 7; i++) begin
            ref_seq[i] = cur;
            cur = {cur[1:0], 1'($countones(cur & m) % 2)};
        end
    endtask

    // Runs one burst and compares every output on every clk against the
    // model, up to one cycle beyond the expected done pulse. A start pulse
    // with scrambled configuration can be injected at cycle poke_t.
    task automatic apply_stimulus(input logic [2:0] m, input logic [2:0] s,
                                  input logic [7:0] d, input logic [7:0] r,
                                  input int poke_t,
                                  output int busy_cnt, output int pe_cnt,
                                  output int done_cnt, output logic [20:0] obs_seq);
        int         chip_clks;
        int         period_clks;
        int         len;
        int         chips_seen;
        logic [2:0] exp_state;
        logic       exp_busy;
        logic       exp_stb;
        logic       exp_pe;
        logic       exp_done;
        build_ref(m, s);
        chip_clks   = int'(d) + 1;
        period_clks = 7 * chip_clks;
        len         = int'(r) * period_clks;
        busy_cnt    = 0;
        pe_cnt      = 0;
        done_cnt    = 0;
        chips_seen  = 0;
        obs_seq     = '0;
        mask_i      = m;
        seed_i      = s;
        sel_div_i   = d;
        rep_i       = r;
        start_i     = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int t = 0; t <= len + 1; t++) begin
            if (t < len) begin
                exp_busy  = 1'b1;
                exp_state = ref_seq[(t / chip_clks) % 7];
                exp_stb   = (t % chip_clks) == 0;
                exp_pe    = (t % period_clks) == (period_clks - 1);
                exp_done  = 1'b0;
            end else begin
                exp_busy  = 1'b0;
                exp_state = 3'd0;
                exp_stb   = 1'b0;
                exp_pe    = 1'b0;
                exp_done  = (t == len);
            end
            check_output($sformatf("busy t=%0d", t), 32'(busy_o), 32'(exp_busy));
            check_output($sformatf("state t=%0d", t), 32'(state_o), 32'(exp_state));
            check_output($sformatf("sig t=%0d", t), 32'(sig_o), 32'(exp_state[2]));
            check_output($sformatf("chip_stb t=%0d", t), 32'(chip_stb_o), 32'(exp_stb));
            check_output($sformatf("period_end t=%0d", t), 32'(period_end_o), 32'(exp_pe));
            check_output($sformatf("done t=%0d", t), 32'(done_o), 32'(exp_done));
            if (busy_o) busy_cnt++;
            if (period_end_o) pe_cnt++;
            if (done_o) done_cnt++;
            if (busy_o && chip_stb_o && chips_seen < 7) begin
                obs_seq[(6 - chips_seen) * 3 +: 3] = state_o;
                chips_seen++;
            end
            if (t == poke_t) begin
                start_i   = 1'b1;
                mask_i    = ~m;
                seed_i    = s + 3'd1;
                sel_div_i = d + 8'd3;
                rep_i     = r + 8'd2;
            end else begin
                start_i   = 1'b0;
                mask_i    = m;
                seed_i    = s;
                sel_div_i = d;
                rep_i     = r;
            end
            @(negedge clk);
        end
    endtask

    // Applies one table entry and compares the summary against its constants.
    task automatic run_vector(input int idx, input int poke_t);
        int          busy_cnt;
        int          pe_cnt;
        int          done_cnt;
        logic [20:0] obs_seq;
        apply_stimulus(vecs[idx].mask, vecs[idx].seed, vecs[idx].div, vecs[idx].rep,
                       poke_t, busy_cnt, pe_cnt, done_cnt, obs_seq);
        check_output($sformatf("vec%0d busy_clks", idx), 32'(busy_cnt), 32'(vecs[idx].exp_busy));
        check_output($sformatf("vec%0d period_ends", idx), 32'(pe_cnt), 32'(vecs[idx].exp_pe));
        check_output($sformatf("vec%0d done_pulses", idx), 32'(done_cnt), 32'd1);
        check_output($sformatf("vec%0d first_period", idx), 32'(obs_seq), 32'(vecs[idx].exp_seq));
    endtask

    initial begin
        int          pe_cnt;
        int          busy_cnt;
        int          done_cnt;
        logic [20:0] obs_seq;

        checks = 0;
        errors = 0;

        // Sequence 111,110,100,001,010,101,011 for mask 110.
        vecs[0] = '{3'b110, 3'b111, 8'd0, 8'd1, 7,   1, 21'b111_110_100_001_010_101_011};
        vecs[1] = '{3'b110, 3'b111, 8'd5, 8'd3, 126, 3, 21'b111_110_100_001_010_101_011};
        vecs[2] = '{3'b110, 3'b000, 8'd0, 8'd1, 7,   1, 21'b111_110_100_001_010_101_011};
        // Zero mask: seed shifts out, zeros shift in.
        vecs[3] = '{3'b000, 3'b101, 8'd1, 8'd2, 28,  2, 21'b101_010_100_000_000_000_000};
        // Non-maximal mask 011 from seed 001 cycles 011,110,101 after the seed.
        vecs[4] = '{3'b011, 3'b001, 8'd0, 8'd1, 7,   1, 21'b001_011_110_101_011_110_101};

        arst      = 1'b1;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        mask_i    = 3'd0;
        seed_i    = 3'd0;
        sel_div_i = 8'd0;
        rep_i     = 8'd0;
        repeat (2) @(negedge clk);

        // Reset state.
        check_output("reset busy", 32'(busy_o), 32'd0);
        check_output("reset state", 32'(state_o), 32'd0);
        check_output("reset sig", 32'(sig_o), 32'd0);
        check_output("reset chip_stb", 32'(chip_stb_o), 32'd0);
        check_output("reset period_end", 32'(period_end_o), 32'd0);
        check_output("reset done", 32'(done_o), 32'd0);
        arst = 1'b0;
        @(negedge clk);

        // Table-driven bursts.
        for (int i = 0; i < 5; i++) begin
            run_vector(i, -1);
            @(negedge clk);
        end

        // Start pulse with different config while busy must not disturb the run.
        $display("[TB] start while busy");
        run_vector(0, 3);
        @(negedge clk);

        // Start together with stop in IDLE is ignored.
        $display("[TB] start and stop together while idle");
        mask_i  = 3'b110;
        seed_i  = 3'b111;
        rep_i   = 8'd1;
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        for (int t = 0; t < 3; t++) begin
            check_output($sformatf("start_stop busy t=%0d", t), 32'(busy_o), 32'd0);
            check_output($sformatf("start_stop state t=%0d", t), 32'(state_o), 32'd0);
            @(negedge clk);
        end

        // Continuous mode, then stop mid-period.
        $display("[TB] continuous mode with stop");
        build_ref(3'b110, 3'b111);
        mask_i    = 3'b110;
        seed_i    = 3'b111;
        sel_div_i = 8'd1;
        rep_i     = 8'd0;
        start_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        pe_cnt  = 0;
        for (int t = 0; t <= 46; t++) begin
            check_output($sformatf("cont busy t=%0d", t), 32'(busy_o), 32'd1);
            check_output($sformatf("cont state t=%0d", t), 32'(state_o), 32'(ref_seq[(t / 2) % 7]));
            check_output($sformatf("cont period_end t=%0d", t), 32'(period_end_o), 32'((t % 14) == 13));
            check_output($sformatf("cont done t=%0d", t), 32'(done_o), 32'd0);
            if (period_end_o) pe_cnt++;
            if (t == 46) stop_i = 1'b1;
            @(negedge clk);
        end
        stop_i = 1'b0;
        check_output("cont period_end count", 32'(pe_cnt), 32'd3);
        for (int t = 0; t < 2; t++) begin
            check_output($sformatf("stopped busy t=%0d", t), 32'(busy_o), 32'd0);
            check_output($sformatf("stopped sig t=%0d", t), 32'(sig_o), 32'd0);
            check_output($sformatf("stopped state t=%0d", t), 32'(state_o), 32'd0);
            check_output($sformatf("stopped period_end t=%0d", t), 32'(period_end_o), 32'd0);
            check_output($sformatf("stopped done t=%0d", t), 32'(done_o), 32'd0);
            @(negedge clk);
        end

        // Back-to-back bursts: a start during the done cycle is accepted.
        $display("[TB] back-to-back bursts");
        mask_i    = 3'b110;
        seed_i    = 3'b111;
        sel_div_i = 8'd0;
        rep_i     = 8'd1;
        start_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        check_output("b2b done", 32'(done_o), 32'd1);
        check_output("b2b idle", 32'(busy_o), 32'd0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check_output("b2b restart busy", 32'(busy_o), 32'd1);
        check_output("b2b restart state", 32'(state_o), 32'd7);
        check_output("b2b restart chip_stb", 32'(chip_stb_o), 32'd1);
        busy_cnt = 0;
        for (int t = 0; t < 20 && busy_o; t++) begin
            busy_cnt++;
            @(negedge clk);
        end
        check_output("b2b second busy_clks", 32'(busy_cnt), 32'd7);
        check_output("b2b second done", 32'(done_o), 32'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of a chip, away from any clk edge.
        $display("[TB] async reset mid-run");
        mask_i    = 3'b110;
        seed_i    = 3'b111;
        sel_div_i = 8'd5;
        rep_i     = 8'd1;
        start_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        check_output("arst busy", 32'(busy_o), 32'd0);
        check_output("arst state", 32'(state_o), 32'd0);
        check_output("arst sig", 32'(sig_o), 32'd0);
        check_output("arst chip_stb", 32'(chip_stb_o), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        check_output("arst done", 32'(done_o), 32'd0);
        @(negedge clk);
        run_vector(0, -1);
        @(negedge clk);

        // Random bursts against the model.
        $display("[TB] random bursts");
        for (int i = 0; i < 12; i++) begin
            logic [2:0] rm;
            logic [2:0] rs;
            logic [7:0] rd;
            logic [7:0] rr;
            int         exp_len;
            rm = 3'($urandom_range(0, 7));
            rs = 3'($urandom_range(0, 7));
            rd = 8'($urandom_range(0, 3));
            rr = 8'($urandom_range(1, 3));
            exp_len = int'(rr) * 7 * (int'(rd) + 1);
            apply_stimulus(rm, rs, rd, rr, -1, busy_cnt, pe_cnt, done_cnt, obs_seq);
            check_output($sformatf("rand%0d busy_clks", i), 32'(busy_cnt), 32'(exp_len));
            check_output($sformatf("rand%0d period_ends", i), 32'(pe_cnt), 32'(rr));
            check_output($sformatf("rand%0d done_pulses", i), 32'(done_cnt), 32'd1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
